// File: rtl/video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_timing_gen: parametrised raster timing with delayed DE/HS/VS     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module video_timing_gen #(
  parameter int   W        = 12,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   DELAY    = 5
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o,
  output logic         active_o,
  output logic         vblank_o,
  output logic         sof_o,
  output logic         eol_o,
  output logic [7:0]   frame_cnt_o,
  output logic         de_o,
  output logic         hs_o,
  output logic         vs_o
);

  localparam logic [31:0] c_H_TOTAL  = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [31:0] c_V_TOTAL  = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [31:0] c_H_ACT    = 32'(H_ACTIVE);
  localparam logic [31:0] c_V_ACT    = 32'(V_ACTIVE);
  localparam logic [31:0] c_HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] c_HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] c_VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] c_VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [32:0] c_CNT_SPAN = 33'(1) << W;

  if ({1'b0, c_H_TOTAL} > c_CNT_SPAN) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL exceeds 2^W");
  end
  if ({1'b0, c_V_TOTAL} > c_CNT_SPAN) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL exceeds 2^W");
  end
  if ((DELAY < 1) || (DELAY > 8)) begin : g_bad_delay
    $error("video_timing_gen: DELAY must be within 1..8");
  end

  logic [W-1:0] r_h;
  logic [W-1:0] r_v;
  logic [7:0]   r_frame_cnt;
  logic [31:0]  w_h32;
  logic [31:0]  w_v32;
  logic         w_h_last;
  logic         w_v_last;
  logic         w_active;
  logic         w_hs_raw;
  logic         w_vs_raw;
  logic [2:0]   r_pipe [DELAY];

  assign w_h32    = 32'(r_h);
  assign w_v32    = 32'(r_v);
  assign w_h_last = (w_h32 == c_H_TOTAL - 32'd1);
  assign w_v_last = (w_v32 == c_V_TOTAL - 32'd1);

  assign w_active = en_i && (w_h32 < c_H_ACT) && (w_v32 < c_V_ACT);
  assign w_hs_raw = en_i && (w_h32 >= c_HS_START) && (w_h32 < c_HS_END);
  assign w_vs_raw = en_i && (w_v32 >= c_VS_START) && (w_v32 < c_VS_END);

  // Disabling snaps the raster back to the origin so re-enable starts a fresh frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_h         <= '0;
      r_v         <= '0;
      r_frame_cnt <= '0;
    end else if (!en_i) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      if (w_v_last) begin
        r_v         <= '0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_v <= r_v + W'(1);
      end
    end else begin
      r_h <= r_h + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pipe[0] <= '0;
    end else begin
      r_pipe[0] <= {w_active, w_hs_raw, w_vs_raw};
    end
  end

  for (genvar i = 1; i < DELAY; i++) begin : g_stage
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_pipe[i] <= '0;
      end else begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign x_o         = r_h;
  assign y_o         = r_v;
  assign active_o    = w_active;
  assign vblank_o    = (w_v32 >= c_V_ACT);
  assign sof_o       = en_i && (r_h == '0) && (r_v == '0);
  assign eol_o       = en_i && w_h_last;
  assign frame_cnt_o = r_frame_cnt;

  // Pipe stores "in sync" as 1; polarity is applied only at the pins.
  assign de_o = r_pipe[DELAY-1][2];
  assign hs_o = r_pipe[DELAY-1][1] ~^ HS_POL;
  assign vs_o = r_pipe[DELAY-1][0] ~^ VS_POL;

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the nano6502 video path. It is the successor to the fixed 640x480 sync logic.
- Produces pixel coordinates, active/blank flags, and DE/HS/VS delayed by a configurable pipeline depth so they line up with downstream text/font/palette stages feeding DVI_TX_Top.
- Adds runtime enable, start-of-frame/end-of-line strobes and a frame counter.

Parameters:
- W, 12, counter and coordinate width (bits)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, HS active level (0 = active-low)
- VS_POL, 0, VS active level (0 = active-low)
- DELAY, 5, cycles from x_o/y_o to de_o/hs_o/vs_o; legal range 1..8

Ports:
- clk_i  in  1  pixel clock
- rst_n_i  in  1  reset, asynchronous, active-low
- en_i  in  1  timing enable
- x_o  out  W  horizontal counter h
- y_o  out  W  vertical counter v
- active_o  out  1  undelayed active-area flag
- vblank_o  out  1  undelayed vertical blank flag
- sof_o  out  1  start-of-frame strobe
- eol_o  out  1  end-of-line strobe
- frame_cnt_o  out  8  frame counter
- de_o  out  1  delayed data enable
- hs_o  out  1  delayed horizontal sync
- vs_o  out  1  delayed vertical sync

Behaviour:
- Reset and clock: rst_n_i is asynchronous, active-low; all logic is clocked by clk_i.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be at most 2^W. Elaboration fails if either exceeds 2^W or DELAY is outside 1..8.
- Counter origin is the first active pixel. h runs 0..H_TOTAL-1 and v runs 0..V_TOTAL-1.
- Counter update when en_i=1:
  - h increments each cycle.
  - At h=H_TOTAL-1, h goes to 0 and v increments.
  - At h=H_TOTAL-1 and v=V_TOTAL-1, both go to 0 and frame_cnt_o increments, wrapping 255->0.
- Counter update when en_i=0: h and v are synchronously forced to 0 (not held at their current value); frame_cnt_o holds.
- x_o/y_o are the h/v registers directly (latency 0).
- Undelayed decodes, combinational from h/v:
  - active_o = (h<H_ACTIVE)&&(v<V_ACTIVE)&&en_i.
  - vblank_o = v>=V_ACTIVE.
  - hs_raw = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs_raw = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. VS edges therefore coincide with h=0.
  - Both sync terms are gated by en_i.
- Strobes:
  - sof_o = en_i && h==0 && v==0; exactly one cycle per frame.
  - eol_o = en_i && h==H_TOTAL-1.
- Delay pipeline: DELAY-stage shift register of {active, hs_raw, vs_raw}. de_o/hs_o/vs_o at cycle t+DELAY reflect the counter state at cycle t.
- Output polarity: hs_o = pipe_hs XNOR HS_POL, i.e. the active level when in sync. vs_o is handled likewise with VS_POL.
- Reset values:
  - h=v=0, frame_cnt_o=0.
  - All pipeline stages inactive, so de_o=0, hs_o=~HS_POL, vs_o=~VS_POL.
  - sof_o/eol_o follow their decode of h=v=0 with en_i.
- en_i falling edge mid-frame:
  - Counters go to 0 on the next edge.
  - Inactive values enter the pipeline, so de_o/hs_o/vs_o go inactive exactly DELAY cycles later.
  - No partial sync pulse is extended.
- en_i rising edge: the first enabled cycle has h=v=0 and sof_o=1. The first de_o=1 appears DELAY cycles later.
- Simultaneous wrap and en_i=0: the disable wins; frame_cnt_o does not increment.

Test Plan:
- Defaults, en_i=1 from reset, run 2 frames:
  - one period between sof_o pulses = 420000 cycles;
  - eol_o every 800 cycles;
  - 307200 de_o cycles per frame;
  - hs_o low for 96 cycles starting at h=656+5 cycles delay;
  - vs_o low for 1600 cycles;
  - frame_cnt_o=2.
- Small config (H 8/2/3/1, V 4/1/2/1, DELAY=1, HS_POL=1):
  - hs_o high exactly at h=10..12 +1 cycle;
  - de_o high 8 cycles per line on lines 0..3;
  - frame length 14*8=112 cycles.
- DELAY sweep 1, 3, 8: the de_o rising edge lags active_o by exactly DELAY cycles.
- en_i dropped at h=300,v=100:
  - x_o/y_o=0 next cycle;
  - de_o low exactly DELAY cycles after the drop;
  - frame_cnt_o unchanged.
- en_i re-asserted: sof_o=1 on the first enabled cycle; frame proceeds normally.
- Async reset asserted mid-line: all outputs take their reset values immediately, without waiting for a clock edge.
- Run 256 frames of the small config: frame_cnt_o wraps to 0.
